// File: rtl/step_rate_scheduler_if.sv
// Control and status bundle between the speed selector side (master) and the stepper scheduler (slave).
interface step_rate_scheduler_if;
    logic       enable;
    logic       dir;
    logic       estop;
    logic [3:0] target_speed;
    logic [3:0] coils;
    logic       step_tick;
    logic [3:0] cur_speed;
    logic       at_speed;
    logic       moving;

    modport master (
        output enable, dir, estop, target_speed,
        input  coils, step_tick, cur_speed, at_speed, moving
    );

    modport slave (
        input  enable, dir, estop, target_speed,
        output coils, step_tick, cur_speed, at_speed, moving
    );
endinterface

// File: rtl/step_rate_scheduler.sv
// Stepper step-rate scheduler: ramped level control, phase-accumulator step ticks and coil sequencing.
// Define HALF_STEP_EN to select the 8-entry half-step coil sequence instead of the 4-entry full-step one.
module step_rate_scheduler #(
    parameter int STEP_DIV   = 500000,
    parameter int ACC_W      = 20,
    parameter int RAMP_STEPS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    step_rate_scheduler_if.slave bus
);
`ifdef HALF_STEP_EN
    localparam int IDX_W = 3;
`else
    localparam int IDX_W = 2;
`endif
    localparam int RC_W = $clog2(RAMP_STEPS + 1);

    typedef enum logic [1:0] {IDLE, ACCEL, RUN, DECEL} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [RC_W-1:0]  ramp_cnt_q, ramp_cnt_d;
    logic [2:0]       cur_speed_q, cur_speed_d;
    logic [IDX_W-1:0] coil_idx_q, coil_idx_d;
    logic             dir_l_q, dir_l_d;
    logic             step_tick_q, step_tick_d;
    logic [3:0]       coils_q, coils_d;
    logic             at_speed_q, at_speed_d;
    logic             moving_q, moving_d;

    logic [2:0]       tgt;
    logic [2:0]       speed_up, speed_dn;
    logic             stop_goal, tick, ramp_event;
    logic [ACC_W-1:0] acc_sum;
    logic [RC_W-1:0]  ramp_inc;

    function automatic logic [3:0] coil_pattern(input logic [IDX_W-1:0] idx);
`ifdef HALF_STEP_EN
        case (idx)
            3'd0:    return 4'b1000;
            3'd1:    return 4'b1100;
            3'd2:    return 4'b0100;
            3'd3:    return 4'b0110;
            3'd4:    return 4'b0010;
            3'd5:    return 4'b0011;
            3'd6:    return 4'b0001;
            default: return 4'b1001;
        endcase
`else
        case (idx)
            2'd0:    return 4'b1100;
            2'd1:    return 4'b0110;
            2'd2:    return 4'b0011;
            default: return 4'b1001;
        endcase
`endif
    endfunction

    assign tgt        = (bus.target_speed > 4'd6) ? 3'd6 : bus.target_speed[2:0];
    assign stop_goal  = !bus.enable || (tgt == 3'd0) || (bus.dir != dir_l_q);
    assign acc_sum    = acc_q + ACC_W'(cur_speed_q);
    assign tick       = (state_q != IDLE) && (acc_sum >= ACC_W'(STEP_DIV));
    assign ramp_inc   = ramp_cnt_q + RC_W'(1);
    assign ramp_event = tick && (state_q != RUN) && (ramp_inc == RC_W'(RAMP_STEPS));
    assign speed_up   = cur_speed_q + 3'd1;
    assign speed_dn   = cur_speed_q - 3'd1;

    // Direction is only latched on leaving IDLE, so a reversal request reads as a stop goal until speed 0.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ramp_cnt_d  = ramp_cnt_q;
        cur_speed_d = cur_speed_q;
        coil_idx_d  = coil_idx_q;
        dir_l_d     = dir_l_q;
        step_tick_d = 1'b0;

        if (bus.estop) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            if (bus.enable && (tgt != 3'd0)) begin
                state_d     = ACCEL;
                dir_l_d     = bus.dir;
                cur_speed_d = 3'd1;
            end
        end else begin
            step_tick_d = tick;
            acc_d       = tick ? (acc_sum - ACC_W'(STEP_DIV)) : acc_sum;
            if (tick) begin
                coil_idx_d = dir_l_q ? (coil_idx_q + IDX_W'(1)) : (coil_idx_q - IDX_W'(1));
            end
            if (tick && (state_q != RUN)) begin
                ramp_cnt_d = ramp_event ? '0 : ramp_inc;
            end
            case (state_q)
                ACCEL: begin
                    if (stop_goal || (tgt < cur_speed_q)) begin
                        state_d = DECEL;
                    end else if (tgt == cur_speed_q) begin
                        state_d = RUN;
                    end else if (ramp_event) begin
                        cur_speed_d = speed_up;
                        if (speed_up == tgt) state_d = RUN;
                    end
                end
                RUN: begin
                    if (stop_goal || (tgt < cur_speed_q)) state_d = DECEL;
                    else if (tgt > cur_speed_q)           state_d = ACCEL;
                end
                DECEL: begin
                    if (ramp_event) begin
                        cur_speed_d = speed_dn;
                        if (speed_dn == 3'd0)                    state_d = IDLE;
                        else if (!stop_goal && (speed_dn == tgt)) state_d = RUN;
                    end else if (!stop_goal && (cur_speed_q == tgt)) begin
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (state_d == RUN) ramp_cnt_d = '0;
        end

        if (state_d == IDLE) begin
            acc_d       = '0;
            ramp_cnt_d  = '0;
            cur_speed_d = '0;
            coil_idx_d  = '0;
        end

        coils_d    = (state_d == IDLE) ? 4'b0000 : coil_pattern(coil_idx_d);
        at_speed_d = (state_d == RUN);
        moving_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ramp_cnt_q  <= '0;
            cur_speed_q <= '0;
            coil_idx_q  <= '0;
            dir_l_q     <= 1'b1;
            step_tick_q <= 1'b0;
            coils_q     <= 4'b0000;
            at_speed_q  <= 1'b0;
            moving_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ramp_cnt_q  <= ramp_cnt_d;
            cur_speed_q <= cur_speed_d;
            coil_idx_q  <= coil_idx_d;
            dir_l_q     <= dir_l_d;
            step_tick_q <= step_tick_d;
            coils_q     <= coils_d;
            at_speed_q  <= at_speed_d;
            moving_q    <= moving_d;
        end
    end

    assign bus.coils     = coils_q;
    assign bus.step_tick = step_tick_q;
    assign bus.cur_speed = {1'b0, cur_speed_q};
    assign bus.at_speed  = at_speed_q;
    assign bus.moving    = moving_q;
endmodule
